// File: rtl/queue_fifo.sv
// queue_fifo: circular-buffer FIFO with registered read port, occupancy
// counter and sticky overflow/underflow flags. Pointers wrap by explicit
// compare so DEPTH need not be a power of two.
module queue_fifo #(
  parameter int DW    = 4,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          push,
  input  logic          pop,
  input  logic          clr_err,
  input  logic [DW-1:0] dataInput,
  output logic [DW-1:0] dataOutput,
  output logic          out_valid,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_dout;
  logic          r_valid;
  logic          r_ovf;
  logic          r_unf;

  logic          w_full;
  logic          w_empty;
  logic          w_pop_ok;
  logic          w_push_ok;
  logic          w_ovf_set;
  logic          w_unf_set;
  logic [PW-1:0] w_wr_ptr_inc;
  logic [PW-1:0] w_rd_ptr_inc;

  // Occupancy decodes and accept/reject decisions for this edge.
  always_comb begin
    w_full       = (r_count == CW'(DEPTH));
    w_empty      = (r_count == '0);
    w_pop_ok     = en & pop & ~w_empty;
    // A pop in the same cycle frees a slot, so a full queue still accepts.
    w_push_ok    = en & push & (~w_full | w_pop_ok);
    w_ovf_set    = en & push & ~w_push_ok;
    w_unf_set    = en & pop & ~w_pop_ok;
    w_wr_ptr_inc = (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
    w_rd_ptr_inc = (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + 1'b1;
  end

  // Storage write; contents are left uninitialised so this maps onto RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= dataInput;
    end
  end

  // Pointers, occupancy, registered read data and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_valid <= w_pop_ok;
      if (en) begin
        if (w_push_ok) begin
          r_wr_ptr <= w_wr_ptr_inc;
        end
        if (w_pop_ok) begin
          r_rd_ptr <= w_rd_ptr_inc;
          r_dout   <= r_mem[r_rd_ptr];
        end
        if (w_push_ok && !w_pop_ok) begin
          r_count <= r_count + 1'b1;
        end else if (w_pop_ok && !w_push_ok) begin
          r_count <= r_count - 1'b1;
        end
        // A new rejection wins over a simultaneous clear.
        r_ovf <= w_ovf_set | (r_ovf & ~clr_err);
        r_unf <= w_unf_set | (r_unf & ~clr_err);
      end
    end
  end

  assign dataOutput = r_dout;
  assign out_valid  = r_valid;
  assign full       = w_full;
  assign empty      = w_empty;
  assign count      = r_count;
  assign overflow   = r_ovf;
  assign underflow  = r_unf;

endmodule
